ws2812_decoder: RTL
===================

WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 SHALL have parameter CLK_FRE, default 27_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BIT_THRESH, default 16, high-pulse cycle count above which a bit decodes as 1.
REQ-003 SHALL have parameter GLITCH_MIN, default 3, minimum legal high-pulse cycles.
REQ-004 SHALL have parameter HIGH_MAX, default 40, maximum legal high-pulse cycles.
REQ-005 SHALL have parameter RESET_CYCLES, default 1350, low cycles marking frame end (50 us at 27 MHz).
REQ-006 SHALL have parameter MAX_LEDS, default 12, pixels accepted per frame.
REQ-007 CLOCK_27  input  1  sole clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 din  input  1  asynchronous WS2812 serial line, e.g. the WS2812 output of the serializer.
REQ-010 pixel_data  output  24  decoded GRB word, first-received bit in bit 23.
REQ-011 pixel_valid  output  1  one-cycle strobe qualifying pixel_data and pixel_index.
REQ-012 pixel_index  output  8  zero-based position of the pixel in the current frame.
REQ-013 frame_done  output  1  one-cycle strobe at detected reset gap.
REQ-014 frame_len  output  8  complete pixels in the frame just ended; valid with frame_done, held until the next frame_done.
REQ-015 bit_error  output  1  one-cycle strobe on any protocol violation.

Function
REQ-016 din SHALL pass a 2-flop synchronizer; all timing counts refer to the synchronized signal.
REQ-017 FSM states SHALL be SYNC, IDLE, HIGH, LOW.
- SYNC: wait until the line has been low for RESET_CYCLES consecutive cycles; then go to IDLE, with no frame_done.
- IDLE: on a rising edge, go to HIGH with the count at 1.
- HIGH: count cycles; on a falling edge, classify the bit and go to LOW.
- LOW: count low cycles; a rising edge goes to HIGH; a low count reaching RESET_CYCLES ends the frame and goes to IDLE.
REQ-018 Bit classification SHALL give 1 if the high count > BIT_THRESH, and 0 otherwise.
REQ-019 Bits SHALL shift into a 24-bit register MSB-first; the bit counter SHALL wrap 23->0.
REQ-020 On the 24th bit, pixel_valid SHALL assert exactly one cycle after the falling edge that completed the pixel.
REQ-021 pixel_index SHALL then increment, saturating at 255.
REQ-022 Pixels with index >= MAX_LEDS SHALL still be counted, SHALL not strobe pixel_valid, and SHALL strobe bit_error once per frame.
REQ-023 At frame end, frame_done SHALL pulse and frame_len SHALL load the pixel count (saturating 255).
REQ-024 At frame end, the pixel and bit counters SHALL clear.
REQ-025 A gap with 1-23 pending bits SHALL discard those bits, pulse bit_error in the same cycle as frame_done, and exclude the partial pixel from frame_len.
REQ-026 A high pulse < GLITCH_MIN cycles SHALL pulse bit_error and SHALL be ignored; bit and pixel state SHALL be unchanged.
REQ-027 A high pulse reaching HIGH_MAX cycles SHALL pulse bit_error, drop the current pixel, and enter SYNC.
REQ-028 Low and high counters SHALL be 12 bits, and SHALL saturate rather than wrap.
REQ-029 If a pixel completion and frame end fall in the same cycle, pixel_valid SHALL precede frame_done by one cycle.
REQ-030 frame_len SHALL include the completed pixel in that case.

Reset
REQ-031 On reset: pixel_data=0, pixel_valid=0, pixel_index=0, frame_done=0, frame_len=0, bit_error=0, all counters=0, state=SYNC.
REQ-032 On reset, both synchronizer flops SHALL be cleared to 0.
REQ-033 Reset mid-frame SHALL discard all partial data, and the first post-reset frame SHALL be accepted only after a full RESET_CYCLES gap.

Structure
REQ-034 Shared package SHALL hold the FSM state encodings and the default timing constants (T0H=11, T1H=22, TRESET=1350 cycles at 27 MHz).
REQ-035 The serializer and the decoder SHALL both use that package.
REQ-036 One sub-module, ws2812_pulse_meter, SHALL contain the synchronizer, edge detect, and saturating high/low counters.
REQ-037 The FSM and the shift register SHALL stay in ws2812_decoder.

Verification
REQ-038 Scenario 1: after reset, a 1350-cycle low, then 24 bits encoding 0xFF0000 (T1H=22/T1L=12, T0H=11/T0L=23), then a 1400-cycle low. Required response: one pixel_valid with data 0xFF0000 and index 0, then frame_done with frame_len=1, and bit_error never asserted.
REQ-039 Scenario 2: 12 pixels 0x000001..0x00000C followed by a gap. Required response: 12 strobes with indexes 0..11 and matching data, then frame_len=12.
REQ-040 Scenario 3: 14 pixels followed by a gap. Required response: 12 pixel_valid strobes, one bit_error strobe, and frame_len=14.
REQ-041 Scenario 4: 10 bits followed by a gap. Required response: no pixel_valid; frame_done and bit_error in the same cycle; frame_len=0.
REQ-042 Scenario 5: a 2-cycle glitch inserted between bits 5 and 6 of 0xA5A5A5. Required response: one bit_error strobe, and the pixel still decodes as 0xA5A5A5.
REQ-043 Scenario 6: reset asserted at bit 12 of a pixel, then 24 bits sent with no gap. Required response: no output until a 1350-cycle low has been seen, after which the next frame decodes correctly.

Source files
------------

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 state encodings, default timing and counter helper
package ws2812_pkg;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      IDLE = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } ws_state_t;

   localparam int CNT_W  = 12;

   // Nominal cycle counts at 27 MHz
   localparam int T0H    = 11;
   localparam int T0L    = 23;
   localparam int T1H    = 22;
   localparam int T1L    = 12;
   localparam int TRESET = 1350;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/ws2812_pulse_meter.sv
// rtl/ws2812_pulse_meter.sv - din synchronizer, edge detect and saturating high/low run-length counters
module ws2812_pulse_meter
   import ws2812_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_din,
   output logic             o_level,
   output logic             o_rise,
   output logic             o_fall,
   output logic [CNT_W-1:0] o_high_cnt,
   output logic [CNT_W-1:0] o_low_cnt
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic [CNT_W-1:0] r_high_cnt;
   logic [CNT_W-1:0] r_low_cnt;

   // Counters hold the number of samples seen at the current level before this cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_prev     <= 1'b0;
         r_high_cnt <= '0;
         r_low_cnt  <= '0;
      end else begin
         r_sync1 <= i_din;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (r_sync2) begin
            r_high_cnt <= r_prev ? sat_inc(r_high_cnt) : CNT_W'(1);
            r_low_cnt  <= '0;
         end else begin
            r_low_cnt  <= r_prev ? CNT_W'(1) : sat_inc(r_low_cnt);
         end
      end
   end

   assign o_level    = r_sync2;
   assign o_rise     = r_sync2 & ~r_prev;
   assign o_fall     = ~r_sync2 & r_prev;
   assign o_high_cnt = r_high_cnt;
   assign o_low_cnt  = r_low_cnt;

endmodule

// File: rtl/ws2812_decoder.sv
// rtl/ws2812_decoder.sv - WS2812 line decoder: bit FSM, pixel shift register and frame accounting
module ws2812_decoder
   import ws2812_pkg::*;
#(
   parameter int CLK_FRE      = 27_000_000,
   parameter int BIT_THRESH   = 16,
   parameter int GLITCH_MIN   = 3,
   parameter int HIGH_MAX     = 40,
   parameter int RESET_CYCLES = TRESET,
   parameter int MAX_LEDS     = 12
)
(
   input  logic        CLOCK_27,
   input  logic        reset,
   input  logic        din,
   output logic [23:0] pixel_data,
   output logic        pixel_valid,
   output logic [7:0]  pixel_index,
   output logic        frame_done,
   output logic [7:0]  frame_len,
   output logic        bit_error
);

   // A zero gap length falls back to 50 us derived from the clock frequency
   localparam int LP_GAP_RAW = (RESET_CYCLES > 0) ? RESET_CYCLES : CLK_FRE / 20_000;
   localparam logic [CNT_W-1:0] LP_GAP    = (LP_GAP_RAW > 4095) ? '1 : CNT_W'(LP_GAP_RAW);
   localparam logic [CNT_W-1:0] LP_THRESH = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] LP_GMIN   = CNT_W'(GLITCH_MIN);
   localparam logic [CNT_W-1:0] LP_HMAX   = CNT_W'(HIGH_MAX);
   localparam logic [7:0]       LP_MAXL   = (MAX_LEDS > 255) ? 8'hFF : 8'(MAX_LEDS);

   logic             w_level;
   logic             w_rise;
   logic             w_fall;
   logic [CNT_W-1:0] w_high_cnt;
   logic [CNT_W-1:0] w_low_cnt;

   ws_state_t        r_state;
   ws_state_t        w_next;
   logic             w_take_bit;
   logic             w_glitch;
   logic             w_overlong;
   logic             w_frame_end;
   logic             w_bit;
   logic [23:0]      w_word;

   logic [22:0]      r_shift;
   logic [4:0]       r_bit_cnt;
   logic [7:0]       r_pix_cnt;
   logic             r_over;

   ws2812_pulse_meter u_meter (
      .i_clk      (CLOCK_27),
      .i_rst      (reset),
      .i_din      (din),
      .o_level    (w_level),
      .o_rise     (w_rise),
      .o_fall     (w_fall),
      .o_high_cnt (w_high_cnt),
      .o_low_cnt  (w_low_cnt)
   );

   assign w_bit  = (w_high_cnt > LP_THRESH);
   assign w_word = {r_shift, w_bit};

   always_ff @(posedge CLOCK_27) begin
      if (reset) r_state <= SYNC;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_take_bit  = 1'b0;
      w_glitch    = 1'b0;
      w_overlong  = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         SYNC: if (!w_level && w_low_cnt >= LP_GAP) w_next = IDLE;
         IDLE: if (w_rise) w_next = HIGH;
         HIGH: begin
            if (w_high_cnt >= LP_HMAX) begin
               w_overlong = 1'b1;
               w_next     = SYNC;
            end else if (w_fall) begin
               if (w_high_cnt < LP_GMIN) begin
                  // A glitch before any data leaves the decoder outside a frame
                  w_glitch = 1'b1;
                  w_next   = (r_bit_cnt == 5'd0 && r_pix_cnt == 8'd0) ? IDLE : LOW;
               end else begin
                  w_take_bit = 1'b1;
                  w_next     = LOW;
               end
            end
         end
         LOW: begin
            if (w_rise) begin
               w_next = HIGH;
            end else if (w_low_cnt >= LP_GAP) begin
               w_frame_end = 1'b1;
               w_next      = IDLE;
            end
         end
         default: w_next = SYNC;
      endcase
   end

   always_ff @(posedge CLOCK_27) begin
      if (reset) begin
         pixel_data  <= '0;
         pixel_valid <= 1'b0;
         pixel_index <= '0;
         frame_done  <= 1'b0;
         frame_len   <= '0;
         bit_error   <= 1'b0;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_pix_cnt   <= '0;
         r_over      <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         bit_error   <= 1'b0;
         if (w_take_bit) begin
            r_shift <= w_word[22:0];
            if (r_bit_cnt == 5'd23) begin
               r_bit_cnt <= '0;
               r_pix_cnt <= (&r_pix_cnt) ? r_pix_cnt : r_pix_cnt + 8'd1;
               if (r_pix_cnt < LP_MAXL) begin
                  pixel_valid <= 1'b1;
                  pixel_data  <= w_word;
                  pixel_index <= r_pix_cnt;
               end else if (!r_over) begin
                  bit_error <= 1'b1;
                  r_over    <= 1'b1;
               end
            end else begin
               r_bit_cnt <= r_bit_cnt + 5'd1;
            end
         end
         if (w_glitch) bit_error <= 1'b1;
         if (w_overlong || w_frame_end) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_pix_cnt <= '0;
            r_over    <= 1'b0;
         end
         if (w_overlong) bit_error <= 1'b1;
         if (w_frame_end) begin
            frame_done <= 1'b1;
            frame_len  <= r_pix_cnt;
            if (r_bit_cnt != 5'd0) bit_error <= 1'b1;
         end
      end
   end

endmodule
